// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg
// Shared definitions for the PS/2 mouse packet decoder:
//   - state_e   : packet framing FSM states (header, X byte, Y byte)
//   - BTN_*/SYNC/XS/YS/XO/YO : bit positions inside the packet header byte
//   - OVF_POS/OVF_NEG        : delta substituted when a header overflow bit is set
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        S_B0,
        S_B1,
        S_B2
    } state_e;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    localparam logic signed [8:0] OVF_POS = 9'sh0FF;  // +255
    localparam logic signed [8:0] OVF_NEG = 9'sh100;  // -256

endpackage

// File: rtl/ps2_motion_accum.sv
// ps2_motion_accum
// One motion axis: decodes the 9-bit signed delta (with overflow substitution),
// accumulates it with saturation, and on each tick registers the scaled,
// clamped magnitude and the direction, then clears the accumulator.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   commit_i   : add this cycle's delta (packet completes this cycle)
//   tick_i     : movement sample point (single-cycle event)
//   byte_i     : low 8 bits of the delta
//   sign_i     : delta sign bit from the header
//   ovf_i      : overflow bit from the header
//   mag_o      : min(|acc| >> SHIFT, 2^OUT_W-1), updated on tick
//   dir_o      : 1 when the accumulated value was >= 0, updated on tick
module ps2_motion_accum
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned ACC_W = 11,
    parameter int unsigned OUT_W = 10,
    parameter int unsigned SHIFT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             commit_i,
    input  logic             tick_i,
    input  logic [7:0]       byte_i,
    input  logic             sign_i,
    input  logic             ovf_i,
    output logic [OUT_W-1:0] mag_o,
    output logic             dir_o
);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(ACC_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;
    localparam logic [ACC_W-1:0]      OUT_MAX = ACC_W'((2**OUT_W) - 1);

    logic signed [ACC_W-1:0] acc_q;
    logic [OUT_W-1:0]        mag_q;
    logic                    dir_q;

    logic signed [8:0]       delta_d;
    logic signed [ACC_W:0]   sum_d;
    logic signed [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0]        abs_d;
    logic [ACC_W-1:0]        mag_d;

    // acc_d already includes a same-cycle commit, so a tick coinciding with
    // the last packet byte reports that packet's motion.
    always_comb begin
        delta_d = '0;
        if (commit_i) begin
            if (ovf_i) begin
                delta_d = sign_i ? OVF_NEG : OVF_POS;
            end else begin
                delta_d = {sign_i, byte_i};
            end
        end
        sum_d = (ACC_W+1)'(acc_q) + (ACC_W+1)'(delta_d);
        if (sum_d > SAT_MAX) begin
            acc_d = SAT_MAX[ACC_W-1:0];
        end else if (sum_d < SAT_MIN) begin
            acc_d = SAT_MIN[ACC_W-1:0];
        end else begin
            acc_d = sum_d[ACC_W-1:0];
        end
        abs_d = acc_d[ACC_W-1] ? ACC_W'(-acc_d) : ACC_W'(acc_d);
        mag_d = abs_d >> SHIFT;
        if (mag_d > OUT_MAX) begin
            mag_d = OUT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
            mag_q <= '0;
            dir_q <= 1'b0;
        end else if (tick_i) begin
            acc_q <= '0;
            mag_q <= mag_d[OUT_W-1:0];
            dir_q <= ~acc_d[ACC_W-1];
        end else begin
            acc_q <= acc_d;
        end
    end

    assign mag_o = mag_q;
    assign dir_o = dir_q;

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder
// Frames 3-byte PS/2 mouse packets from the byte receiver, resynchronises on
// stray bytes and inter-byte timeouts, and reports per-tick motion.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   rx_ready/rx_data : receiver strobe level (rising edge = new byte) and byte
//   move_tick        : movement clock level (rising edge = sample point)
//   pkt_valid        : one-cycle pulse per accepted packet
//   btn_left/right/middle : button levels from the last accepted packet
//   vx, vy, dir_x, dir_y  : scaled magnitude and direction per tick interval
//   sync_err_cnt     : saturating count of dropped bytes and timeouts
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned SHIFT          = 1,
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned ACC_W          = 11
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       move_tick,
    output logic       pkt_valid,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic [9:0] vx,
    output logic [8:0] vy,
    output logic       dir_x,
    output logic       dir_y,
    output logic [7:0] sync_err_cnt
);

    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q;
    logic            rx_q;
    logic            tick_q;
    logic [7:0]      hdr_q;
    logic [7:0]      xbyte_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [7:0]      err_q;
    logic            pkt_valid_q;
    logic            btn_l_q;
    logic            btn_r_q;
    logic            btn_m_q;

    logic            rx_evt_d;
    logic            tick_evt_d;
    logic            commit_d;
    logic [7:0]      err_d;

    always_comb begin
        rx_evt_d   = rx_ready & ~rx_q;
        tick_evt_d = move_tick & ~tick_q;
        commit_d   = rx_evt_d && (state_q == S_B2);
        err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_B0;
            rx_q        <= 1'b0;
            tick_q      <= 1'b0;
            hdr_q       <= '0;
            xbyte_q     <= '0;
            to_cnt_q    <= '0;
            err_q       <= '0;
            pkt_valid_q <= 1'b0;
            btn_l_q     <= 1'b0;
            btn_r_q     <= 1'b0;
            btn_m_q     <= 1'b0;
        end else begin
            rx_q        <= rx_ready;
            tick_q      <= move_tick;
            pkt_valid_q <= 1'b0;
            case (state_q)
                S_B0: begin
                    to_cnt_q <= '0;
                    if (rx_evt_d) begin
                        // Only a byte with the always-one sync bit can start a packet.
                        if (rx_data[SYNC]) begin
                            hdr_q   <= rx_data;
                            state_q <= S_B1;
                        end else begin
                            err_q <= err_d;
                        end
                    end
                end
                S_B1: begin
                    if (rx_evt_d) begin
                        xbyte_q  <= rx_data;
                        to_cnt_q <= '0;
                        state_q  <= S_B2;
                    end else if (to_cnt_q == TO_LAST) begin
                        to_cnt_q <= '0;
                        err_q    <= err_d;
                        state_q  <= S_B0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_B2: begin
                    // The Y byte is consumed straight from rx_data by the Y accumulator.
                    if (rx_evt_d) begin
                        pkt_valid_q <= 1'b1;
                        btn_l_q     <= hdr_q[BTN_L];
                        btn_r_q     <= hdr_q[BTN_R];
                        btn_m_q     <= hdr_q[BTN_M];
                        to_cnt_q    <= '0;
                        state_q     <= S_B0;
                    end else if (to_cnt_q == TO_LAST) begin
                        to_cnt_q <= '0;
                        err_q    <= err_d;
                        state_q  <= S_B0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                default: begin
                    to_cnt_q <= '0;
                    state_q  <= S_B0;
                end
            endcase
        end
    end

    ps2_motion_accum #(
        .ACC_W (ACC_W),
        .OUT_W (10),
        .SHIFT (SHIFT)
    ) u_accum_x (
        .clk      (clk),
        .rstn     (rstn),
        .commit_i (commit_d),
        .tick_i   (tick_evt_d),
        .byte_i   (xbyte_q),
        .sign_i   (hdr_q[XS]),
        .ovf_i    (hdr_q[XO]),
        .mag_o    (vx),
        .dir_o    (dir_x)
    );

    ps2_motion_accum #(
        .ACC_W (ACC_W),
        .OUT_W (9),
        .SHIFT (SHIFT)
    ) u_accum_y (
        .clk      (clk),
        .rstn     (rstn),
        .commit_i (commit_d),
        .tick_i   (tick_evt_d),
        .byte_i   (rx_data),
        .sign_i   (hdr_q[YS]),
        .ovf_i    (hdr_q[YO]),
        .mag_o    (vy),
        .dir_o    (dir_y)
    );

    assign pkt_valid    = pkt_valid_q;
    assign btn_left     = btn_l_q;
    assign btn_right    = btn_r_q;
    assign btn_middle   = btn_m_q;
    assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed bench for ps2_mouse_packet_decoder. Two instances share stimulus:
// u_dut1 with SHIFT=1 and u_dut0 with SHIFT=0, both with a short timeout.
module tb_ps2_mouse_packet_decoder;

    localparam int unsigned TO = 40;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       move_tick = 1'b0;

    logic       pv1, bl1, br1, bm1, dx1, dy1;
    logic [9:0] vx1;
    logic [8:0] vy1;
    logic [7:0] err1;
    logic       pv0, bl0, br0, bm0, dx0, dy0;
    logic [9:0] vx0;
    logic [8:0] vy0;
    logic [7:0] err0;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (pv1) pv_cnt++;

    ps2_mouse_packet_decoder #(.SHIFT(1), .TIMEOUT_CYCLES(TO), .ACC_W(11)) u_dut1 (
        .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .rx_data(rx_data), .move_tick(move_tick),
        .pkt_valid(pv1), .btn_left(bl1), .btn_right(br1), .btn_middle(bm1),
        .vx(vx1), .vy(vy1), .dir_x(dx1), .dir_y(dy1), .sync_err_cnt(err1));

    ps2_mouse_packet_decoder #(.SHIFT(0), .TIMEOUT_CYCLES(TO), .ACC_W(11)) u_dut0 (
        .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .rx_data(rx_data), .move_tick(move_tick),
        .pkt_valid(pv0), .btn_left(bl0), .btn_right(br0), .btn_middle(bm0),
        .vx(vx0), .vy(vy0), .dir_x(dx0), .dir_y(dy0), .sync_err_cnt(err0));

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y);
        send_byte(h);
        send_byte(x);
        send_byte(y);
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        move_tick = 1'b1;
        @(posedge clk); #1;
        move_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pv1 !== 1'b0)   begin errors++; $display("FAIL rst_pv got %0d exp 0", pv1); end
        checks++; if ({bl1, br1, bm1} !== 3'b000) begin errors++; $display("FAIL rst_btn got %0b exp 000", {bl1, br1, bm1}); end
        checks++; if (vx1 !== 10'd0)  begin errors++; $display("FAIL rst_vx got %0d exp 0", vx1); end
        checks++; if (vy1 !== 9'd0)   begin errors++; $display("FAIL rst_vy got %0d exp 0", vy1); end
        checks++; if ({dx1, dy1} !== 2'b00) begin errors++; $display("FAIL rst_dir got %0b exp 00", {dx1, dy1}); end
        checks++; if (err1 !== 8'd0)  begin errors++; $display("FAIL rst_err got %0d exp 0", err1); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        send_byte(8'h09);
        send_byte(8'h05);
        @(posedge clk); #1;
        rx_data = 8'h03;
        rx_ready = 1'b1;
        checks++; if (pv1 !== 1'b0) begin errors++; $display("FAIL basic_pv_early got %0d exp 0", pv1); end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        checks++; if (pv1 !== 1'b1) begin errors++; $display("FAIL basic_pv_pulse got %0d exp 1", pv1); end
        checks++; if (bl1 !== 1'b1) begin errors++; $display("FAIL basic_btn_l got %0d exp 1", bl1); end
        checks++; if (vx1 !== 10'd0) begin errors++; $display("FAIL basic_vx_hold got %0d exp 0", vx1); end
        @(posedge clk); #1;
        checks++; if (pv1 !== 1'b0) begin errors++; $display("FAIL basic_pv_clear got %0d exp 0", pv1); end
        do_tick();
        checks++; if (vx1 !== 10'd2) begin errors++; $display("FAIL basic_vx1 got %0d exp 2", vx1); end
        checks++; if (vy1 !== 9'd1)  begin errors++; $display("FAIL basic_vy1 got %0d exp 1", vy1); end
        checks++; if ({dx1, dy1} !== 2'b11) begin errors++; $display("FAIL basic_dir got %0b exp 11", {dx1, dy1}); end
        checks++; if (vx0 !== 10'd5) begin errors++; $display("FAIL basic_vx0 got %0d exp 5", vx0); end
        checks++; if (vy0 !== 9'd3)  begin errors++; $display("FAIL basic_vy0 got %0d exp 3", vy0); end
    endtask

    task automatic test_negative();
        send_pkt(8'h38, 8'hFB, 8'h00);
        do_tick();
        checks++; if (vx0 !== 10'd5)   begin errors++; $display("FAIL neg_vx0 got %0d exp 5", vx0); end
        checks++; if (vy0 !== 9'd256)  begin errors++; $display("FAIL neg_vy0 got %0d exp 256", vy0); end
        checks++; if ({dx0, dy0} !== 2'b00) begin errors++; $display("FAIL neg_dir got %0b exp 00", {dx0, dy0}); end
        checks++; if (vx1 !== 10'd2)   begin errors++; $display("FAIL neg_vx1 got %0d exp 2", vx1); end
        checks++; if (vy1 !== 9'd128)  begin errors++; $display("FAIL neg_vy1 got %0d exp 128", vy1); end
        checks++; if (bl1 !== 1'b0)    begin errors++; $display("FAIL neg_btn_l got %0d exp 0", bl1); end
    endtask

    task automatic test_resync();
        do_reset();
        send_byte(8'h05);
        send_pkt(8'h0A, 8'h10, 8'h20);
        do_tick();
        checks++; if (err1 !== 8'd1) begin errors++; $display("FAIL resync_err got %0d exp 1", err1); end
        checks++; if ({bl1, br1, bm1} !== 3'b010) begin errors++; $display("FAIL resync_btn got %0b exp 010", {bl1, br1, bm1}); end
        checks++; if (vx1 !== 10'd8) begin errors++; $display("FAIL resync_vx1 got %0d exp 8", vx1); end
        checks++; if (vy1 !== 9'd16) begin errors++; $display("FAIL resync_vy1 got %0d exp 16", vy1); end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = pv_cnt;
        send_byte(8'h09);
        send_byte(8'h05);
        repeat (TO + 5) @(posedge clk);
        #1;
        checks++; if (err1 !== 8'd1) begin errors++; $display("FAIL to_err_expire got %0d exp 1", err1); end
        send_byte(8'h08);
        send_byte(8'h02);
        repeat (TO - 5) @(posedge clk);
        send_byte(8'h04);
        do_tick();
        checks++; if (pv_cnt - base !== 1) begin errors++; $display("FAIL to_pkts got %0d exp 1", pv_cnt - base); end
        checks++; if (err1 !== 8'd1) begin errors++; $display("FAIL to_err_final got %0d exp 1", err1); end
        checks++; if (vx0 !== 10'd2) begin errors++; $display("FAIL to_vx0 got %0d exp 2", vx0); end
        checks++; if (vy0 !== 9'd4)  begin errors++; $display("FAIL to_vy0 got %0d exp 4", vy0); end
        checks++; if (bl1 !== 1'b0)  begin errors++; $display("FAIL to_btn_l got %0d exp 0", bl1); end
    endtask

    task automatic test_accumulate();
        repeat (3) send_pkt(8'h08, 8'h64, 8'h00);
        do_tick();
        checks++; if (vx1 !== 10'd150) begin errors++; $display("FAIL acc_vx1 got %0d exp 150", vx1); end
        checks++; if (vx0 !== 10'd300) begin errors++; $display("FAIL acc_vx0 got %0d exp 300", vx0); end
        do_tick();
        checks++; if (vx1 !== 10'd0) begin errors++; $display("FAIL acc_idle_vx1 got %0d exp 0", vx1); end
        checks++; if (dx1 !== 1'b1)  begin errors++; $display("FAIL acc_idle_dx1 got %0d exp 1", dx1); end
    endtask

    task automatic test_saturation();
        repeat (5) send_pkt(8'hC8, 8'h00, 8'h00);
        do_tick();
        checks++; if (vx0 !== 10'd1023) begin errors++; $display("FAIL satp_vx0 got %0d exp 1023", vx0); end
        checks++; if (vy0 !== 9'd511)   begin errors++; $display("FAIL satp_vy0 got %0d exp 511", vy0); end
        checks++; if (vx1 !== 10'd511)  begin errors++; $display("FAIL satp_vx1 got %0d exp 511", vx1); end
        checks++; if ({dx0, dy0} !== 2'b11) begin errors++; $display("FAIL satp_dir got %0b exp 11", {dx0, dy0}); end
        repeat (5) send_pkt(8'hF8, 8'h00, 8'h00);
        do_tick();
        checks++; if (vx0 !== 10'd1023) begin errors++; $display("FAIL satn_vx0 got %0d exp 1023", vx0); end
        checks++; if (vx1 !== 10'd511)  begin errors++; $display("FAIL satn_vx1 got %0d exp 511", vx1); end
        checks++; if ({dx0, dy0} !== 2'b00) begin errors++; $display("FAIL satn_dir got %0b exp 00", {dx0, dy0}); end
    endtask

    task automatic test_simultaneous();
        send_byte(8'h08);
        send_byte(8'h0A);
        @(posedge clk); #1;
        rx_data = 8'h00;
        rx_ready = 1'b1;
        move_tick = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        move_tick = 1'b0;
        checks++; if (pv1 !== 1'b1)   begin errors++; $display("FAIL sim_pv got %0d exp 1", pv1); end
        checks++; if (vx0 !== 10'd10) begin errors++; $display("FAIL sim_vx0 got %0d exp 10", vx0); end
        checks++; if (dx0 !== 1'b1)   begin errors++; $display("FAIL sim_dx0 got %0d exp 1", dx0); end
        do_tick();
        checks++; if (vx0 !== 10'd0)  begin errors++; $display("FAIL sim_clear_vx0 got %0d exp 0", vx0); end
    endtask

    task automatic test_mid_reset();
        send_byte(8'h05);
        send_pkt(8'h0F, 8'h20, 8'h20);
        do_tick();
        checks++; if (vx0 !== 10'd32) begin errors++; $display("FAIL mr_pre_vx0 got %0d exp 32", vx0); end
        send_byte(8'h09);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++; if ({bl1, br1, bm1} !== 3'b000) begin errors++; $display("FAIL mr_btn got %0b exp 000", {bl1, br1, bm1}); end
        checks++; if (vx0 !== 10'd0) begin errors++; $display("FAIL mr_vx0 got %0d exp 0", vx0); end
        checks++; if (vy0 !== 9'd0)  begin errors++; $display("FAIL mr_vy0 got %0d exp 0", vy0); end
        checks++; if ({dx0, dy0} !== 2'b00) begin errors++; $display("FAIL mr_dir got %0b exp 00", {dx0, dy0}); end
        checks++; if (err1 !== 8'd0) begin errors++; $display("FAIL mr_err got %0d exp 0", err1); end
        rstn = 1'b1;
        send_pkt(8'h08, 8'h06, 8'h02);
        do_tick();
        checks++; if (vx0 !== 10'd6) begin errors++; $display("FAIL mr_post_vx0 got %0d exp 6", vx0); end
        checks++; if (vy0 !== 9'd2)  begin errors++; $display("FAIL mr_post_vy0 got %0d exp 2", vy0); end
        checks++; if (err1 !== 8'd0) begin errors++; $display("FAIL mr_post_err got %0d exp 0", err1); end
    endtask

    task automatic test_err_saturate();
        do_reset();
        repeat (255) send_byte(8'h00);
        checks++; if (err1 !== 8'd255) begin errors++; $display("FAIL errsat_255 got %0d exp 255", err1); end
        repeat (5) send_byte(8'h00);
        checks++; if (err1 !== 8'd255) begin errors++; $display("FAIL errsat_hold got %0d exp 255", err1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_resync();
        test_timeout();
        test_accumulate();
        test_saturation();
        test_simultaneous();
        test_mid_reset();
        test_err_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
# ps2_mouse_packet_decoder

Turns the byte stream from the PS/2 byte receiver (`ps2_keyboard`, strobe `ready`, byte `data`) into mouse motion for `objectMouseMove`. It frames standard 3-byte PS/2 mouse packets, resynchronises on bad or stalled packets, and accumulates signed X/Y deltas between movement ticks. On each tick it presents a scaled magnitude plus direction per axis, and it also presents button levels. It replaces the ad-hoc packet capture in the top level.

## Interface
Parameters:
- `SHIFT`, 1: right-shift applied to accumulated magnitude before output.
- `TIMEOUT_CYCLES`, 2500000: idle clocks allowed between bytes of one packet.
- `ACC_W`, 11: signed accumulator width; saturates at ±(2^(ACC_W-1)−1).

Ports:
- `clk` in 1: system clock (Div[0] domain).
- `rstn` in 1: reset, synchronous, active-low.
- `rx_ready` in 1: receiver byte-ready level; a rising edge marks a new byte.
- `rx_data` in 8: received byte, valid while `rx_ready`=1.
- `move_tick` in 1: movement clock level (clock_100ms); the rising edge is the sample point.
- `pkt_valid` out 1: one-cycle pulse per accepted packet.
- `btn_left`, `btn_right`, `btn_middle` out 1 each: button levels from the last accepted packet.
- `vx` out 10: X magnitude for the last tick interval.
- `vy` out 9: Y magnitude for the last tick interval.
- `dir_x` out 1: 1 = accumulated X ≥ 0 (rightwards).
- `dir_y` out 1: 1 = accumulated Y ≥ 0 (PS/2 up).
- `sync_err_cnt` out 8: saturating count of dropped bytes and timeouts.

## Operation
- Edge detect: `rx_ready` and `move_tick` are each registered once. An event is `x & ~x_q`.
- FSM states are S_B0, S_B1 and S_B2.
  - S_B0: a byte with bit3=1 is latched as the header and the FSM goes to S_B1. A byte with bit3=0 is dropped, `sync_err_cnt`++, and the FSM stays in S_B0.
  - S_B1: the byte is latched as X and the FSM goes to S_B2.
  - S_B2: the byte is latched as Y, the packet commits, and the FSM goes to S_B0.
- Timeout: the counter clears on every accepted byte and in S_B0. In S_B1 or S_B2, when the count reaches TIMEOUT_CYCLES−1, the FSM goes to S_B0, the partial packet is discarded, and `sync_err_cnt`++.
- Delta decode, with hdr the header byte:
  - dx = sign-extend {hdr[4], X}. If hdr[6]=1, dx = hdr[4] ? −256 : +255.
  - dy = sign-extend {hdr[5], Y}. If hdr[7]=1, dy = hdr[5] ? −256 : +255.
- Commit:
  - `btn_left`=hdr[0], `btn_right`=hdr[1], `btn_middle`=hdr[2].
  - acc_x += dx and acc_y += dy, each saturating to ±(2^(ACC_W-1)−1).
- Tick: mag = |acc| >> SHIFT.
  - `vx` = min(mag, 1023) and `vy` = min(mag, 511).
  - `dir_*` = ~acc sign.
  - Both accumulators clear to 0.
- Simultaneous commit and tick: the committed delta is added first. The tick output includes it, and the accumulators clear.
- `sync_err_cnt` holds at 255.

## Timing
- Reset (rstn=0 at a clk edge) takes effect on that edge:
  - FSM goes to S_B0 and the accumulators and timeout counter go to 0.
  - All outputs go to 0.
  - Edge-detect registers go to 0. If `rx_ready` is high at release, it is therefore taken as a new byte.
  - Reset mid-packet discards the partial packet.
- Byte edge at cycle N: the byte is latched at N+1.
- Third-byte edge at cycle N: `pkt_valid`=1, buttons update, and accumulators update, all at N+1. `pkt_valid` clears at N+2.
- Tick edge at cycle M: `vx`, `vy`, `dir_x` and `dir_y` update at M+1 and hold until the next tick.
- Throughput: one byte per 2 cycles minimum, since `rx_ready` must fall between bytes.

## Structure
- `ps2_mouse_pkg` holds:
  - the FSM state enum;
  - header bit positions (BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7);
  - the overflow substitution constants.
- Sub-module `ps2_motion_accum` (parameter ACC_W, OUT_W) is instantiated once per axis. It does delta decode, saturating accumulation, and magnitude/direction registering on tick.

## Test plan
- Packet 0x09,0x05,0x03, then a tick, SHIFT=1 -> `pkt_valid` pulse; `btn_left`=1; `vx`=2, `dir_x`=1; `vy`=1, `dir_y`=1.
- Packet 0x38,0xFB,0x00, then a tick, SHIFT=0 -> dx=−5, dy=−256: `vx`=5, `dir_x`=0; `vy`=256, `dir_y`=0.
- Stray byte 0x05 then a valid packet -> `sync_err_cnt`=1; the packet decodes correctly.
- Header then X byte, then 2500000 idle clocks, then a fresh packet -> `sync_err_cnt`=1; only the fresh packet commits.
- Three packets with X=+100 each, then a tick, SHIFT=1 -> `vx`=150. A further tick with no packets -> `vx`=0, `dir_x`=1.
- rstn pulsed low after the header byte -> all outputs are 0. The next three bytes form a full packet.
